// File: rtl/spi_yanitlayici.sv
// SPI responder: oversampled SCK/CS/MOSI, MSB-first word shifting in all four
// CPOL/CPHA modes, with local TX and RX word FIFOs.
module spi_yanitlayici #(
    parameter int unsigned FIFO_DERINLIK = 8,
    parameter int unsigned KELIME        = 32
) (
    input  logic              clk_g,
    input  logic              rst_g,
    input  logic              cpol_g,
    input  logic              cpha_g,
    input  logic              spi_sck_g,
    input  logic              spi_cs_g,
    input  logic              spi_mosi_g,
    output logic              spi_miso_c,
    output logic              spi_miso_oe_c,
    input  logic [KELIME-1:0] tx_veri_g,
    input  logic              tx_gecerli_g,
    output logic              tx_hazir_c,
    output logic [KELIME-1:0] rx_veri_c,
    output logic              rx_gecerli_c,
    input  logic              rx_hazir_g,
    output logic [3:0]        tx_sayi_c,
    output logic [3:0]        rx_sayi_c,
    output logic              tx_eksik_c,
    output logic              rx_tasma_c,
    input  logic              bayrak_sil_g,
    output logic              mesgul_c
);
    localparam int unsigned AW = $clog2(FIFO_DERINLIK);
    localparam int unsigned SW = $clog2(FIFO_DERINLIK + 1);
    localparam int unsigned BW = $clog2(KELIME);

    // BEKLE: after reset, wait until CS is seen high before accepting a transfer
    typedef enum logic [1:0] {BEKLE, IDLE, AKTIF} durum_t;

    logic [2:0]        sck_p;
    logic [2:0]        cs_p;
    logic [1:0]        mosi_p;
    logic [1:0]        sy_dolu;
    durum_t            durum;
    logic              cpol_r;
    logic              cpha_r;
    logic              need_load;
    logic [BW-1:0]     bit_cnt;
    logic [KELIME-1:0] tx_sh;
    logic [KELIME-2:0] rx_sh;
    logic              miso_r;
    logic              oe_r;
    logic              eksik_r;
    logic              tasma_r;
    logic [KELIME-1:0] tx_mem [FIFO_DERINLIK];
    logic [KELIME-1:0] rx_mem [FIFO_DERINLIK];
    logic [AW-1:0]     tx_wr;
    logic [AW-1:0]     tx_rd;
    logic [AW-1:0]     rx_wr;
    logic [AW-1:0]     rx_rd;
    logic [SW-1:0]     tx_cnt;
    logic [SW-1:0]     rx_cnt;

    logic              sck_yuk;
    logic              sck_dus;
    logic              on_kenar;
    logic              arka_kenar;
    logic              aktif_cs;
    logic              giris;
    logic              ornek;
    logic              kaydir;
    logic              kelime_tamam;
    logic              yukle;
    logic              tx_bos;
    logic              tx_baypas;
    logic              tx_rd_en;
    logic              tx_wr_en;
    logic              eksik_set;
    logic              rx_rd_en;
    logic              rx_wr_en;
    logic              tasma_set;
    logic [KELIME-1:0] tx_yukle_veri;
    logic [KELIME-1:0] rx_word;

    // Edge classification relative to the mode latched at CS fall
    assign sck_yuk    = sck_p[1] & ~sck_p[2];
    assign sck_dus    = ~sck_p[1] & sck_p[2];
    assign on_kenar   = cpol_r ? sck_dus : sck_yuk;
    assign arka_kenar = cpol_r ? sck_yuk : sck_dus;
    assign aktif_cs   = (durum == AKTIF) && !cs_p[1];
    assign giris      = (durum == IDLE) && cs_p[2] && !cs_p[1];
    assign ornek      = aktif_cs && (cpha_r ? arka_kenar : on_kenar);
    assign kaydir     = aktif_cs && (cpha_r ? on_kenar : arka_kenar);
    assign kelime_tamam = ornek && (bit_cnt == BW'(KELIME - 1));
    assign rx_word    = {rx_sh, mosi_p[1]};

    // A load from an empty FIFO takes a word pushed in the same cycle directly
    assign yukle         = (giris && !cpha_g) || (kaydir && need_load);
    assign tx_bos        = (tx_cnt == '0);
    assign tx_baypas     = yukle && tx_bos && tx_gecerli_g;
    assign tx_rd_en      = yukle && !tx_bos;
    assign tx_wr_en      = tx_gecerli_g && (tx_hazir_c || tx_rd_en) && !tx_baypas;
    assign eksik_set     = yukle && tx_bos && !tx_gecerli_g;
    assign tx_yukle_veri = !tx_bos ? tx_mem[tx_rd] : (tx_gecerli_g ? tx_veri_g : '0);

    assign rx_rd_en  = rx_gecerli_c && rx_hazir_g;
    assign rx_wr_en  = kelime_tamam && ((rx_cnt != SW'(FIFO_DERINLIK)) || rx_rd_en);
    assign tasma_set = kelime_tamam && !rx_wr_en;

    assign spi_miso_c    = miso_r;
    assign spi_miso_oe_c = oe_r;
    assign tx_hazir_c    = (tx_cnt != SW'(FIFO_DERINLIK));
    assign rx_gecerli_c  = (rx_cnt != '0);
    assign rx_veri_c     = rx_gecerli_c ? rx_mem[rx_rd] : '0;
    assign tx_sayi_c     = 4'(tx_cnt);
    assign rx_sayi_c     = 4'(rx_cnt);
    assign tx_eksik_c    = eksik_r;
    assign rx_tasma_c    = tasma_r;
    assign mesgul_c      = ~cs_p[1];

    always_ff @(posedge clk_g) begin
        if (tx_wr_en) tx_mem[tx_wr] <= tx_veri_g;
        if (rx_wr_en) rx_mem[rx_wr] <= rx_word;
    end

    always_ff @(posedge clk_g) begin
        if (rst_g) begin
            sck_p     <= '0;
            cs_p      <= '1;
            mosi_p    <= '0;
            sy_dolu   <= '0;
            durum     <= BEKLE;
            cpol_r    <= 1'b0;
            cpha_r    <= 1'b0;
            need_load <= 1'b0;
            bit_cnt   <= '0;
            tx_sh     <= '0;
            rx_sh     <= '0;
            miso_r    <= 1'b0;
            oe_r      <= 1'b0;
            eksik_r   <= 1'b0;
            tasma_r   <= 1'b0;
            tx_wr     <= '0;
            tx_rd     <= '0;
            rx_wr     <= '0;
            rx_rd     <= '0;
            tx_cnt    <= '0;
            rx_cnt    <= '0;
        end else begin
            sck_p   <= {sck_p[1:0], spi_sck_g};
            cs_p    <= {cs_p[1:0], spi_cs_g};
            mosi_p  <= {mosi_p[0], spi_mosi_g};
            sy_dolu <= {sy_dolu[0], 1'b1};

            // FIFO bookkeeping
            if (tx_wr_en) tx_wr <= tx_wr + AW'(1);
            if (tx_rd_en) tx_rd <= tx_rd + AW'(1);
            tx_cnt <= tx_cnt + SW'(tx_wr_en) - SW'(tx_rd_en);
            if (rx_wr_en) rx_wr <= rx_wr + AW'(1);
            if (rx_rd_en) rx_rd <= rx_rd + AW'(1);
            rx_cnt <= rx_cnt + SW'(rx_wr_en) - SW'(rx_rd_en);

            eksik_r <= eksik_set | (eksik_r & ~bayrak_sil_g);
            tasma_r <= tasma_set | (tasma_r & ~bayrak_sil_g);

            case (durum)
                BEKLE: begin
                    miso_r <= 1'b0;
                    oe_r   <= 1'b0;
                    if (sy_dolu[1] && cs_p[1]) durum <= IDLE;
                end
                IDLE: begin
                    miso_r <= 1'b0;
                    oe_r   <= 1'b0;
                    if (giris) begin
                        durum     <= AKTIF;
                        oe_r      <= 1'b1;
                        cpol_r    <= cpol_g;
                        cpha_r    <= cpha_g;
                        bit_cnt   <= '0;
                        need_load <= cpha_g;
                        if (!cpha_g) tx_sh <= tx_yukle_veri;
                    end
                end
                AKTIF: begin
                    if (cs_p[1]) begin
                        durum     <= IDLE;
                        bit_cnt   <= '0;
                        need_load <= 1'b0;
                        oe_r      <= 1'b0;
                        miso_r    <= 1'b0;
                    end else begin
                        miso_r <= tx_sh[KELIME-1];
                        if (kaydir) begin
                            if (need_load) begin
                                tx_sh     <= tx_yukle_veri;
                                need_load <= 1'b0;
                            end else begin
                                tx_sh <= {tx_sh[KELIME-2:0], 1'b0};
                            end
                        end
                        if (ornek) begin
                            rx_sh <= rx_word[KELIME-2:0];
                            if (kelime_tamam) begin
                                bit_cnt   <= '0;
                                need_load <= 1'b1;
                            end else begin
                                bit_cnt <= bit_cnt + BW'(1);
                            end
                        end
                    end
                end
                default: durum <= BEKLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_yanitlayici.sv
// Self-checking bench for spi_yanitlayici: the bench acts as SPI controller and
// predicts MISO words, RX contents, counts and flags from a word-level queue model.
module tb_spi_yanitlayici;
    logic        clk_g = 1'b0;
    logic        rst_g = 1'b1;
    logic        cpol_g = 1'b0;
    logic        cpha_g = 1'b0;
    logic        spi_sck_g = 1'b0;
    logic        spi_cs_g = 1'b1;
    logic        spi_mosi_g = 1'b0;
    logic        spi_miso_c;
    logic        spi_miso_oe_c;
    logic [31:0] tx_veri_g = '0;
    logic        tx_gecerli_g = 1'b0;
    logic        tx_hazir_c;
    logic [31:0] rx_veri_c;
    logic        rx_gecerli_c;
    logic        rx_hazir_g = 1'b0;
    logic [3:0]  tx_sayi_c;
    logic [3:0]  rx_sayi_c;
    logic        tx_eksik_c;
    logic        rx_tasma_c;
    logic        bayrak_sil_g = 1'b0;
    logic        mesgul_c;

    spi_yanitlayici dut (
        .clk_g(clk_g), .rst_g(rst_g), .cpol_g(cpol_g), .cpha_g(cpha_g),
        .spi_sck_g(spi_sck_g), .spi_cs_g(spi_cs_g), .spi_mosi_g(spi_mosi_g),
        .spi_miso_c(spi_miso_c), .spi_miso_oe_c(spi_miso_oe_c),
        .tx_veri_g(tx_veri_g), .tx_gecerli_g(tx_gecerli_g), .tx_hazir_c(tx_hazir_c),
        .rx_veri_c(rx_veri_c), .rx_gecerli_c(rx_gecerli_c), .rx_hazir_g(rx_hazir_g),
        .tx_sayi_c(tx_sayi_c), .rx_sayi_c(rx_sayi_c), .tx_eksik_c(tx_eksik_c),
        .rx_tasma_c(rx_tasma_c), .bayrak_sil_g(bayrak_sil_g), .mesgul_c(mesgul_c)
    );

    always #5 clk_g = ~clk_g;

    int vec = 0;
    int bad = 0;

    // Word-level reference model
    logic [31:0] m_tx [$];
    logic [31:0] m_rx [$];
    logic        m_eksik = 1'b0;
    logic        m_tasma = 1'b0;

    logic [31:0] mo [5];
    logic [31:0] mi [5];

    typedef struct {
        bit          pol;
        bit          pha;
        int          nw;
        logic [31:0] tx0, tx1, mo0, mo1;
        logic [31:0] exp_mi0, exp_mi1, exp_rx_head;
        logic [3:0]  exp_rxn;
        logic [3:0]  exp_txn;
    } vec_t;

    task automatic chk(input string ad, input logic [31:0] gercek, input logic [31:0] beklenen);
        vec++;
        if (gercek !== beklenen) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", ad, gercek, beklenen);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk_g);
    endtask

    task automatic chk_state();
        chk("tx_sayi", 32'(tx_sayi_c), 32'(m_tx.size()));
        chk("rx_sayi", 32'(rx_sayi_c), 32'(m_rx.size()));
        chk("tx_eksik", 32'(tx_eksik_c), 32'(m_eksik));
        chk("rx_tasma", 32'(rx_tasma_c), 32'(m_tasma));
        chk("tx_hazir", 32'(tx_hazir_c), 32'(m_tx.size() < 8));
        chk("rx_gecerli", 32'(rx_gecerli_c), 32'(m_rx.size() != 0));
    endtask

    task automatic chk_reset(input string ad);
        chk({ad, " miso"}, 32'(spi_miso_c), 0);
        chk({ad, " oe"}, 32'(spi_miso_oe_c), 0);
        chk({ad, " tx_hazir"}, 32'(tx_hazir_c), 1);
        chk({ad, " rx_gecerli"}, 32'(rx_gecerli_c), 0);
        chk({ad, " rx_veri"}, rx_veri_c, 0);
        chk({ad, " tx_sayi"}, 32'(tx_sayi_c), 0);
        chk({ad, " rx_sayi"}, 32'(rx_sayi_c), 0);
        chk({ad, " tx_eksik"}, 32'(tx_eksik_c), 0);
        chk({ad, " rx_tasma"}, 32'(rx_tasma_c), 0);
        chk({ad, " mesgul"}, 32'(mesgul_c), 0);
    endtask

    task automatic push_tx(input logic [31:0] w);
        chk("push tx_hazir", 32'(tx_hazir_c), 32'(m_tx.size() < 8));
        tx_veri_g = w;
        tx_gecerli_g = 1'b1;
        clks(1);
        tx_gecerli_g = 1'b0;
        if (m_tx.size() < 8) m_tx.push_back(w);
    endtask

    task automatic pop_rx();
        logic [31:0] w;
        w = m_rx.pop_front();
        chk("pop rx_gecerli", 32'(rx_gecerli_c), 1);
        chk("pop rx_veri", rx_veri_c, w);
        rx_hazir_g = 1'b1;
        clks(1);
        rx_hazir_g = 1'b0;
    endtask

    task automatic drain();
        while (m_rx.size() != 0) pop_rx();
        chk("drained rx_veri", rx_veri_c, 0);
        chk("drained rx_sayi", 32'(rx_sayi_c), 0);
    endtask

    task automatic clr_flags();
        bayrak_sil_g = 1'b1;
        clks(1);
        bayrak_sil_g = 1'b0;
        m_eksik = 1'b0;
        m_tasma = 1'b0;
        chk("clr tx_eksik", 32'(tx_eksik_c), 0);
        chk("clr rx_tasma", 32'(rx_tasma_c), 0);
    endtask

    task automatic xfer_begin(input bit pol, input bit pha);
        cpol_g = pol;
        cpha_g = pha;
        spi_sck_g = pol;
        clks(4);
        if (!pha) spi_mosi_g = mo[0][31];
        spi_cs_g = 1'b0;
        clks(8);
    endtask

    task automatic xfer_end();
        clks(4);
        spi_cs_g = 1'b1;
        clks(6);
    endtask

    // One SCK period; MISO is read two clocks after the controller's sample edge
    task automatic bit_cycle(input bit pol, input bit pha, input int i, input int nbits);
        if (!pha) begin
            spi_sck_g = ~pol;
            clks(2);
            mi[i / 32][31 - i % 32] = spi_miso_c;
            clks(2);
            spi_sck_g = pol;
            if (i + 1 < nbits) spi_mosi_g = mo[(i + 1) / 32][31 - (i + 1) % 32];
            clks(4);
        end else begin
            spi_sck_g = ~pol;
            spi_mosi_g = mo[i / 32][31 - i % 32];
            clks(4);
            spi_sck_g = pol;
            clks(2);
            mi[i / 32][31 - i % 32] = spi_miso_c;
            clks(2);
        end
    endtask

    // Full transfer of nbits under one CS low, checked against the queue model
    task automatic xfer(input bit pol, input bit pha, input int nbits);
        int          nw, nwt, loads, nb;
        logic [31:0] ex [5];
        logic [31:0] mask;
        nw = nbits / 32;
        nwt = (nbits + 31) / 32;
        // cpha=0 reloads on the idle-return edge after every completed word
        loads = pha ? nwt : nw + 1;
        for (int k = 0; k < 5; k++) begin
            ex[k] = '0;
            mi[k] = '0;
        end
        for (int k = 0; k < loads; k++) begin
            if (m_tx.size() != 0) ex[k] = m_tx.pop_front();
            else m_eksik = 1'b1;
        end
        xfer_begin(pol, pha);
        chk("active oe", 32'(spi_miso_oe_c), 1);
        chk("active mesgul", 32'(mesgul_c), 1);
        for (int i = 0; i < nbits; i++) bit_cycle(pol, pha, i, nbits);
        xfer_end();
        for (int k = 0; k < nwt; k++) begin
            nb = (nbits - 32 * k > 32) ? 32 : nbits - 32 * k;
            mask = 32'hFFFF_FFFF << (32 - nb);
            chk($sformatf("miso m%0d%0d w%0d", pol, pha, k), mi[k] & mask, ex[k] & mask);
        end
        for (int k = 0; k < nw; k++) begin
            if (m_rx.size() < 8) m_rx.push_back(mo[k]);
            else m_tasma = 1'b1;
        end
        chk_state();
        chk("idle oe", 32'(spi_miso_oe_c), 0);
        chk("idle mesgul", 32'(mesgul_c), 0);
    endtask

    initial begin
        vec_t tbl [4];
        tbl[0] = '{0, 0, 1, 32'hA5A5_1234, 32'h0, 32'hDEAD_BEEF, 32'h0,
                   32'hA5A5_1234, 32'h0, 32'hDEAD_BEEF, 4'd1, 4'd0};
        tbl[1] = '{0, 1, 2, 32'h1111_1111, 32'h2222_2222, 32'h0F0F_0F0F, 32'hF0F0_F0F0,
                   32'h1111_1111, 32'h2222_2222, 32'h0F0F_0F0F, 4'd2, 4'd0};
        tbl[2] = '{1, 0, 2, 32'h1111_1111, 32'h2222_2222, 32'h0F0F_0F0F, 32'hF0F0_F0F0,
                   32'h1111_1111, 32'h2222_2222, 32'h0F0F_0F0F, 4'd2, 4'd0};
        tbl[3] = '{1, 1, 2, 32'h1111_1111, 32'h2222_2222, 32'h0F0F_0F0F, 32'hF0F0_F0F0,
                   32'h1111_1111, 32'h2222_2222, 32'h0F0F_0F0F, 4'd2, 4'd0};
        for (int k = 0; k < 5; k++) mo[k] = '0;

        clks(3);
        chk_reset("reset");
        rst_g = 1'b0;
        clks(5);

        // Mode table
        for (int t = 0; t < 4; t++) begin
            push_tx(tbl[t].tx0);
            if (tbl[t].nw == 2) push_tx(tbl[t].tx1);
            mo[0] = tbl[t].mo0;
            mo[1] = tbl[t].mo1;
            xfer(tbl[t].pol, tbl[t].pha, tbl[t].nw * 32);
            chk($sformatf("t%0d miso0", t), mi[0], tbl[t].exp_mi0);
            if (tbl[t].nw == 2) chk($sformatf("t%0d miso1", t), mi[1], tbl[t].exp_mi1);
            chk($sformatf("t%0d rx_sayi", t), 32'(rx_sayi_c), 32'(tbl[t].exp_rxn));
            chk($sformatf("t%0d rx_head", t), rx_veri_c, tbl[t].exp_rx_head);
            chk($sformatf("t%0d tx_sayi", t), 32'(tx_sayi_c), 32'(tbl[t].exp_txn));
            drain();
            clr_flags();
        end

        // Underrun: empty TX FIFO sends zeros and raises the sticky flag
        mo[0] = 32'h1234_5678;
        xfer(1'b0, 1'b1, 32);
        chk("underrun miso", mi[0], 32'h0);
        chk("underrun flag", 32'(tx_eksik_c), 1);
        clr_flags();
        drain();

        // Overflow: nine words without pops, ninth dropped
        for (int k = 1; k <= 9; k++) begin
            mo[0] = 32'h5A00_0000 | 32'(k);
            xfer(1'b0, 1'b1, 32);
        end
        chk("ovf rx_sayi", 32'(rx_sayi_c), 8);
        chk("ovf flag", 32'(rx_tasma_c), 1);
        chk("ovf first", rx_veri_c, 32'h5A00_0001);
        drain();
        clr_flags();

        // CS rises after 13 bits; next word starts from bit 0
        push_tx(32'h7777_0001);
        push_tx(32'h7777_0002);
        mo[0] = 32'hFFFF_FFFF;
        xfer(1'b0, 1'b0, 13);
        chk("abort rx_sayi", 32'(rx_sayi_c), 0);
        mo[0] = 32'h3C3C_5A5A;
        xfer(1'b0, 1'b0, 32);
        chk("after abort miso", mi[0], 32'h7777_0002);
        chk("after abort rx", rx_veri_c, 32'h3C3C_5A5A);
        drain();
        clr_flags();

        // Reset mid-word with CS held low
        push_tx(32'h1357_9BDF);
        push_tx(32'h2468_ACE0);
        mo[0] = 32'hCAFE_F00D;
        mi[0] = '0;
        xfer_begin(1'b0, 1'b0);
        for (int i = 0; i < 10; i++) bit_cycle(1'b0, 1'b0, i, 32);
        rst_g = 1'b1;
        clks(2);
        chk_reset("midreset");
        m_tx.delete();
        m_rx.delete();
        m_eksik = 1'b0;
        m_tasma = 1'b0;
        rst_g = 1'b0;
        mi[0] = '0;
        for (int i = 10; i < 32; i++) bit_cycle(1'b0, 1'b0, i, 32);
        chk("postreset miso", mi[0], 32'h0);
        chk("postreset oe", 32'(spi_miso_oe_c), 0);
        chk("postreset rx_sayi", 32'(rx_sayi_c), 0);
        chk("postreset tx_eksik", 32'(tx_eksik_c), 0);
        xfer_end();
        push_tx(32'h0BAD_CAFE);
        mo[0] = 32'h600D_F00D;
        xfer(1'b0, 1'b0, 32);
        chk("newcs miso", mi[0], 32'h0BAD_CAFE);
        chk("newcs rx", rx_veri_c, 32'h600D_F00D);
        drain();
        clr_flags();

        // Randomized transfers against the model
        for (int r = 0; r < 14; r++) begin
            bit pol, pha;
            int nbits, np;
            pol = 1'($urandom_range(0, 1));
            pha = 1'($urandom_range(0, 1));
            np = int'($urandom_range(0, 3));
            for (int p = 0; p < np; p++) push_tx($urandom);
            if ($urandom_range(0, 3) == 0) nbits = int'($urandom_range(1, 95));
            else nbits = 32 * int'($urandom_range(1, 3));
            for (int k = 0; k < 4; k++) mo[k] = $urandom;
            xfer(pol, pha, nbits);
            if (m_rx.size() > 5 || $urandom_range(0, 1) == 1) drain();
            if ($urandom_range(0, 2) == 0) clr_flags();
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end

endmodule
